// File: rtl/xera4_video_pkg.sv
// xera4_video_pkg: shared constants and types for the XERA4 video scan-out.
// Holds the 640x480@60 VGA timing, the 320x200x4bpp framebuffer geometry,
// the 12-bit colour type and the fixed grey mapping used when the palette
// option (XERA4_VIDEO_PALETTE_EN) is not built.
package xera4_video_pkg;

    // Horizontal timing in pixel clocks: active, front porch, sync, back porch.
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines: active, front porch, sync, back porch.
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Framebuffer geometry: two 4-bit pixels per byte.
    localparam int unsigned FB_W           = 320;
    localparam int unsigned FB_H           = 200;
    localparam int unsigned BYTES_PER_LINE = 160;
    localparam int unsigned FB_BYTES       = 32000;

    typedef logic [11:0] rgb12_t;

    // Fixed 16-level grey: the nibble drives all three channels.
    function automatic rgb12_t grey12(input logic [3:0] n);
        return {n, n, n};
    endfunction

endpackage

// File: rtl/xera4_palette.sv
// xera4_palette: 16-entry x 12-bit register palette with an asynchronous read.
// Built only when XERA4_VIDEO_PALETTE_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (entry i resets to {i,i,i})
//   i_we       : write strobe
//   i_widx     : entry written
//   i_wrgb     : {R,G,B} written
//   i_ridx     : entry looked up
//   o_rrgb     : looked-up colour; a write becomes visible the cycle after its edge
`ifdef XERA4_VIDEO_PALETTE_EN
module xera4_palette
    import xera4_video_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_we,
    input  logic [3:0] i_widx,
    input  rgb12_t     i_wrgb,
    input  logic [3:0] i_ridx,
    output rgb12_t     o_rrgb
);

    rgb12_t r_pal [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_pal[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (i_we) begin
            r_pal[i_widx] <= i_wrgb;
        end
    end

    // Read returns the pre-edge contents, so a same-cycle write/read sees the old value.
    assign o_rrgb = r_pal[i_ridx];

endmodule
`endif

// File: rtl/xera4_video_scan.sv
// xera4_video_scan: scans the 320x200x4bpp XERA4 framebuffer and drives
// 640x480@60 VGA, doubling every source pixel in both directions and
// centring the 400-line image between V_BORDER-line borders.
// Option: XERA4_VIDEO_PALETTE_EN adds a writable 16x12 palette; without it
// each nibble is shown as a fixed grey level.
// Ports:
//   clk, rst_n         : pixel clock, asynchronous active-low reset
//   vram_addr          : VRAM read byte address (registered)
//   vram_data          : VRAM read data, one clock after the address
//   vga_hs, vga_vs     : active-low syncs, delayed with the colour
//   vga_r/g/b          : 4-bit colour channels
//   vblank_start       : one-clock pulse at hcnt==0, vcnt==480 (counter timing)
//   pal_we/idx/rgb     : palette write port (XERA4_VIDEO_PALETTE_EN only)
module xera4_video_scan
    import xera4_video_pkg::*;
#(
    parameter rgb12_t      BORDER_RGB = 12'h000,
    parameter int unsigned V_BORDER   = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vblank_start
`ifdef XERA4_VIDEO_PALETTE_EN
    ,
    input  logic        pal_we,
    input  logic [3:0]  pal_idx,
    input  logic [11:0] pal_rgb
`endif
);

    localparam logic [9:0] HCNT_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] VCNT_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] IMG_TOP  = 10'(V_BORDER);
    localparam logic [9:0] IMG_BOT  = 10'(V_BORDER + 2 * FB_H);

    // Stage 0: raster counters.
    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == HCNT_MAX) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == VCNT_MAX) ? '0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 10'd1;
        end
    end

    assign vblank_start = (r_hcnt == '0) && (r_vcnt == V_ACT);

    logic        w_active;
    logic        w_image;
    logic        w_fetch;
    logic        w_hs_on;
    logic        w_vs_on;
    logic [7:0]  w_y;
    logic [7:0]  w_k;
    logic [14:0] w_addr;

    assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    // Image lines that fall outside the active columns are treated as blanking.
    assign w_image  = w_active && (r_vcnt >= IMG_TOP) && (r_vcnt < IMG_BOT);
    assign w_fetch  = w_image && (r_hcnt[1:0] == 2'b00);
    assign w_hs_on  = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
    assign w_vs_on  = (r_vcnt >= VS_START) && (r_vcnt < VS_END);

    // y*160 + k as shifts; the image-region gate keeps this within 0..31999.
    assign w_y    = 8'((r_vcnt - IMG_TOP) >> 1);
    assign w_k    = r_hcnt[9:2];
    assign w_addr = {w_y, 7'b0} + {2'b0, w_y, 5'b0} + {7'b0, w_k};

    // Stage 1: address register plus the control that travels with it.
    logic [14:0] r_vram_addr;
    logic        r_s1_active;
    logic        r_s1_image;
    logic        r_s1_lo;
    logic        r_s1_hs_on;
    logic        r_s1_vs_on;

    // Stage 2: control aligned with vram_data.
    logic        r_s2_active;
    logic        r_s2_image;
    logic        r_s2_lo;
    logic        r_s2_hs_on;
    logic        r_s2_vs_on;

    // Stage 3: output registers.
    rgb12_t      r_rgb;
    logic        r_hs;
    logic        r_vs;

    logic [3:0]  w_nib;
    rgb12_t      w_pix;
    rgb12_t      w_colour;

    // Screen columns 4k..4k+1 show the high nibble, 4k+2..4k+3 the low nibble.
    assign w_nib = r_s2_lo ? vram_data[3:0] : vram_data[7:4];

`ifdef XERA4_VIDEO_PALETTE_EN
    xera4_palette u_palette (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (pal_we),
        .i_widx (pal_idx),
        .i_wrgb (pal_rgb),
        .i_ridx (w_nib),
        .o_rrgb (w_pix)
    );
`else
    assign w_pix = grey12(w_nib);
`endif

    always_comb begin
        w_colour = 12'h000;
        if (r_s2_image) begin
            w_colour = w_pix;
        end else if (r_s2_active) begin
            w_colour = BORDER_RGB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vram_addr <= '0;
            r_s1_active <= 1'b0;
            r_s1_image  <= 1'b0;
            r_s1_lo     <= 1'b0;
            r_s1_hs_on  <= 1'b0;
            r_s1_vs_on  <= 1'b0;
            r_s2_active <= 1'b0;
            r_s2_image  <= 1'b0;
            r_s2_lo     <= 1'b0;
            r_s2_hs_on  <= 1'b0;
            r_s2_vs_on  <= 1'b0;
            r_rgb       <= '0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
        end else begin
            if (w_fetch) begin
                r_vram_addr <= w_addr;
            end
            r_s1_active <= w_active;
            r_s1_image  <= w_image;
            r_s1_lo     <= r_hcnt[1];
            r_s1_hs_on  <= w_hs_on;
            r_s1_vs_on  <= w_vs_on;
            r_s2_active <= r_s1_active;
            r_s2_image  <= r_s1_image;
            r_s2_lo     <= r_s1_lo;
            r_s2_hs_on  <= r_s1_hs_on;
            r_s2_vs_on  <= r_s1_vs_on;
            r_rgb       <= w_colour;
            r_hs        <= ~r_s2_hs_on;
            r_vs        <= ~r_s2_vs_on;
        end
    end

    assign vram_addr = r_vram_addr;
    assign vga_r     = r_rgb[11:8];
    assign vga_g     = r_rgb[7:4];
    assign vga_b     = r_rgb[3:0];
    assign vga_hs    = r_hs;
    assign vga_vs    = r_vs;

endmodule

// File: tb/tb_xera4_video_scan.sv
// Bench for xera4_video_scan. The model tracks the raster position as a
// linear pixel index (0..419999) and derives every output from the raster
// rules; long stretches of the frame are skipped by forcing the counters
// to a chosen position, which the model follows.
module tb_xera4_video_scan;

    localparam int FRAME = 800 * 525;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] vram_addr;
    logic [7:0]  vram_data = 8'h00;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vblank_start;
`ifdef XERA4_VIDEO_PALETTE_EN
    logic        pal_we = 1'b0;
    logic [3:0]  pal_idx = 4'd0;
    logic [11:0] pal_rgb = 12'h000;
    logic [11:0] pal_m [16];
`endif

    xera4_video_scan #(
        .BORDER_RGB (12'hF00),
        .V_BORDER   (40)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vram_addr    (vram_addr),
        .vram_data    (vram_data),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vblank_start (vblank_start)
`ifdef XERA4_VIDEO_PALETTE_EN
        ,
        .pal_we       (pal_we),
        .pal_idx      (pal_idx),
        .pal_rgb      (pal_rgb)
`endif
    );

    always #20 clk = ~clk;

    logic [7:0] mem [32000];
    always @(posedge clk) vram_data <= mem[vram_addr];

    int errors = 0;
    int checks = 0;
    int n      = 0;   // samples since the last reset release
    int pos    = 0;   // raster position the counters hold now
    int d1     = -1;  // positions 1..3 samples ago; -1 = before reset release
    int d2     = -1;
    int d3     = -1;
    int m_addr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (sample %0d, pos %0d)", name, act, exp, n,
                     pos);
        end
    endtask

    function automatic int addr_of(input int p);
        return ((p / 800 - 40) / 2) * 160 + (p % 800) / 4;
    endfunction

    function automatic bit fetch_at(input int p);
        int h;
        int v;
        h = p % 800;
        v = p / 800;
        return (h < 640) && (v >= 40) && (v < 440) && (h % 4 == 0);
    endfunction

    function automatic logic [11:0] colour_of(input logic [3:0] nib);
`ifdef XERA4_VIDEO_PALETTE_EN
        return pal_m[nib];
`else
        return {nib, nib, nib};
`endif
    endfunction

    function automatic logic [11:0] pix_of(input int p);
        int h;
        int v;
        logic [7:0] b;
        h = p % 800;
        v = p / 800;
        if (h >= 640 || v >= 480) return 12'h000;
        if (v < 40 || v >= 440) return 12'hF00;
        b = mem[addr_of(p)];
        return colour_of((h % 4 < 2) ? b[7:4] : b[3:0]);
    endfunction

    task automatic model_reset();
        pos = 0;
        d1 = -1;
        d2 = -1;
        d3 = -1;
        m_addr = 0;
        n = 0;
`ifdef XERA4_VIDEO_PALETTE_EN
        for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
`endif
    endtask

    // One clock: sample at the falling edge and compare everything.
    task automatic cycle();
        logic [11:0] e_rgb;
        int e_hs;
        int e_vs;
        int h3;
        int v3;
        @(negedge clk);
        n++;
        d3 = d2;
        d2 = d1;
        d1 = pos;
        pos = (pos + 1) % FRAME;
        if (d1 >= 0 && fetch_at(d1)) m_addr = addr_of(d1);
        if (d3 < 0) begin
            e_rgb = 12'h000;
            e_hs = 1;
            e_vs = 1;
        end else begin
            h3 = d3 % 800;
            v3 = d3 / 800;
            e_rgb = pix_of(d3);
            e_hs = (h3 >= 656 && h3 < 752) ? 0 : 1;
            e_vs = (v3 >= 490 && v3 < 492) ? 0 : 1;
        end
        chk("rgb", int'({vga_r, vga_g, vga_b}), int'(e_rgb));
        chk("hs", int'(vga_hs), e_hs);
        chk("vs", int'(vga_vs), e_vs);
        chk("vblank_start", int'(vblank_start), (pos == 480 * 800) ? 1 : 0);
        chk("vram_addr", int'(vram_addr), m_addr);
        chk("addr_bound", (int'(vram_addr) <= 31999) ? 1 : 0, 1);
        // Hand-computed pins for the model itself.
        if (d1 == 439 * 800 + 636) chk("addr_last", int'(vram_addr), 31999);
        if (n == 3) chk("border_first", int'({vga_r, vga_g, vga_b}), 12'hF00);
        if (n == 643) chk("hblank_rgb", int'({vga_r, vga_g, vga_b}), 0);
        if (n == 658) chk("hs_before", int'(vga_hs), 1);
        if (n == 659) chk("hs_fall", int'(vga_hs), 0);
        if (n == 754) chk("hs_last", int'(vga_hs), 0);
        if (n == 755) chk("hs_rise", int'(vga_hs), 1);
        if (n == 32001) chk("addr_l40_0", int'(vram_addr), 0);
        if (n == 32005) chk("addr_l40_1", int'(vram_addr), 1);
        if (n == 32637) chk("addr_l40_159", int'(vram_addr), 159);
        if (n == 32801) chk("addr_l41_0", int'(vram_addr), 0);
`ifndef XERA4_VIDEO_PALETTE_EN
        if (n == 32003 || n == 32004) chk("px_hi", int'({vga_r, vga_g, vga_b}), 12'hAAA);
        if (n == 32005 || n == 32006) chk("px_lo", int'({vga_r, vga_g, vga_b}), 12'h555);
`endif
`ifdef XERA4_VIDEO_PALETTE_EN
        if (pal_we) pal_m[pal_idx] = pal_rgb;
`endif
    endtask

    // Move the raster counters to position p between clock edges.
    task automatic jump(input int p);
        #2;
        force dut.r_hcnt = 10'(p % 800);
        force dut.r_vcnt = 10'(p / 800);
        #1;
        release dut.r_hcnt;
        release dut.r_vcnt;
        pos = p;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
        chk({tag, "_hs"}, int'(vga_hs), 1);
        chk({tag, "_vs"}, int'(vga_vs), 1);
        chk({tag, "_addr"}, int'(vram_addr), 0);
        chk({tag, "_vblank"}, int'(vblank_start), 0);
    endtask

    initial begin
        int vb_cnt;
        for (int i = 0; i < 32000; i++) mem[i] = 8'((i * 29 + (i >> 5)) & 255);
        mem[0] = 8'hA5;

        // Power-on reset held for 5 clocks.
        repeat (2) @(negedge clk);
        chk_reset_values("por");
        repeat (3) @(negedge clk);
        release_reset();

        // Top border, first image lines, horizontal timing.
        repeat (33000) cycle();

        // End of the image and start of the bottom border.
        jump(438 * 800);
        repeat (2400) cycle();

        // Vertical blanking and sync.
        jump(479 * 800);
        vb_cnt = 0;
        repeat (12000) begin
            cycle();
            if (vblank_start) vb_cnt++;
        end
        chk("vblank_count", vb_cnt, 1);

        // Frame wrap 524 -> 0.
        jump(524 * 800);
        repeat (1700) cycle();

        // Mid-frame reset on line 200 while hs is low and vram_addr is nonzero.
        jump(200 * 800 + 600);
        repeat (100) cycle();
        chk("pre_reset_hs", int'(vga_hs), 0);
        #5;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async");
        repeat (3) @(negedge clk);
        release_reset();
        repeat (700) cycle();

`ifdef XERA4_VIDEO_PALETTE_EN
        // Palette write while scanning a framebuffer full of 8'h33.
        #5;
        rst_n = 1'b0;
        for (int i = 0; i < 32000; i++) mem[i] = 8'h33;
        repeat (2) @(negedge clk);
        release_reset();
        repeat (10) cycle();
        jump(40 * 800);
        repeat (100) cycle();
        chk("pal_before", int'({vga_r, vga_g, vga_b}), 12'h333);
        pal_we = 1'b1;
        pal_idx = 4'd3;
        pal_rgb = 12'h0F0;
        cycle();
        pal_we = 1'b0;
        chk("pal_same_cycle", int'({vga_r, vga_g, vga_b}), 12'h333);
        cycle();
        chk("pal_after", int'({vga_r, vga_g, vga_b}), 12'h0F0);
        repeat (200) cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xera4_video_scan.md
# xera4_video_scan

- Downstream consumer of the XERA4 framebuffer: scans 32000-byte, 320x200, 4-bit-per-pixel video RAM and drives a 640x480@60 VGA output.
- Each source pixel is doubled horizontally and vertically, giving a 640x400 image centred vertically with 40-line borders top and bottom.
- Owns the VRAM read port; the CPU owns the write port.

## Interface
Parameters:
- BORDER_RGB, 12'h000: colour for active-area lines outside the 400-line image.
- V_BORDER, 40: blank lines above the image.

Ports:
- clk  in  1  pixel clock, 25.175 MHz; all logic on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- vram_addr  out  15  VRAM read byte address.
- vram_data  in  8  VRAM read data; synchronous RAM with 1-clock latency.
- vga_hs  out  1  horizontal sync, active-low.
- vga_vs  out  1  vertical sync, active-low.
- vga_r, vga_g, vga_b  out  4 each  colour.
- vblank_start  out  1  one-clock pulse at the start of vertical blanking, for CPU frame sync.
- pal_we  in  1  palette write strobe (XERA4_VIDEO_PALETTE_EN only).
- pal_idx  in  4  palette entry (XERA4_VIDEO_PALETTE_EN only).
- pal_rgb  in  12  {R,G,B} value (XERA4_VIDEO_PALETTE_EN only).

## Operation
- **Counters:** hcnt 0..799 and vcnt 0..524. hcnt wraps 799->0; vcnt increments on that wrap and wraps 524->0.
- **Active area:** hcnt<640 and vcnt<480.
- **Image region:** V_BORDER <= vcnt < V_BORDER+400.
  - Source row y = (vcnt-V_BORDER)>>1.
  - Source byte k = hcnt>>2.
- **Address:** vram_addr = y*160 + k, computed as (y<<7)+(y<<5)+k in 15 bits. Maximum is 31999; it never exceeds this.
- **Fetch:** a new address is issued when hcnt[1:0]==0 inside the image region. vram_addr holds its last value otherwise.
- **Nibble order:** the high nibble is the left source pixel (screen columns 4k, 4k+1); the low nibble is the right pixel (4k+2, 4k+3).
- **Colour selection:**
  - Inside the image region, colour = palette(nibble).
  - Active area outside the image region = BORDER_RGB.
  - Outside the active area, RGB = 0.
- **Sync:**
  - vga_hs is low for 656<=hcnt<752.
  - vga_vs is low for 490<=vcnt<492.
- **vblank_start:** asserted for exactly the cycle in which hcnt==0 and vcnt==480, in counter timing (not delayed).
- **Reset values:**
  - Counters, vram_addr, RGB and all pipeline registers = 0.
  - vga_hs = vga_vs = 1.
  - vblank_start = 0.
- **Reset mid-frame:** aborts the frame immediately. After release, counting restarts at hcnt=0, vcnt=0 with no partial line.

## Timing
- Pipeline latency is fixed at 3 clocks from counter position to outputs. vga_r/g/b, vga_hs and vga_vs all carry the same 3-clock delay.
  - Stage 1: address registered.
  - Stage 2: RAM data returns.
  - Stage 3: nibble select, palette lookup, output register.
- A pixel at counter (h,v) appears on the pins 3 clocks later. Sync edges stay aligned to colour.
- Frame = 800*525 = 420000 clocks.
- Line 0 of each frame shows stale data if VRAM is written during scan. No tearing protection; the CPU uses vblank_start.

## Configuration
Macro: XERA4_VIDEO_PALETTE_EN.

Defined:
- Ports pal_we, pal_idx and pal_rgb exist, backed by a 16x12 register palette.
- Reset value of entry i is {i,i,i}.
- A write on a clock edge is visible to lookups in the following cycle.
- A write and a lookup of the same index in the same cycle return the old value.

Undefined:
- No palette ports.
- Colour = {n,n,n} for nibble n, i.e. fixed 16-level grey.

## Structure
- Package xera4_video_pkg holds:
  - horizontal timing constants (640/16/96/48) and vertical timing constants (480/10/2/33);
  - FB_W=320, FB_H=200, BYTES_PER_LINE=160, FB_BYTES=32000;
  - typedef rgb12_t.
- One sub-module, xera4_palette, holds the palette register file and lookup. It is conditionally compiled under the macro; the grey mapping is used otherwise.

## Test plan
- **Reset and frame timing:** hold rst_n low 5 clocks, release.
  - hs falls at hcnt 656+3 and lasts 96 clocks.
  - vs is low for 2 lines starting at line 490.
  - Frame length is 420000 clocks.
  - vblank_start pulses once per frame.
- **Address sequence:** on line vcnt=40, vram_addr steps 0,1,...,159. On vcnt=41 it repeats 0..159. On vcnt=439 it ends at 31999. No address exceeds 31999.
- **Pixel mapping:** VRAM byte 0 = 8'hA5, grey build.
  - Screen columns 0-1 of line 40 show RGB 4'hA.
  - Columns 2-3 show RGB 4'h5.
  - The colour appears 3 clocks after the counter position.
- **Border and blanking:** set BORDER_RGB=12'hF00.
  - Lines 0-39 and 440-479 output F,0,0 across 640 columns.
  - hcnt>=640 and vcnt>=480 output 0.
- **Palette (macro on):** write idx 3 = 12'h0F0 while scanning a VRAM full of 8'h33. Pixels change to green from the cycle after the write; earlier pixels stay grey 3.
- **Mid-frame reset:** assert rst_n at vcnt=200. Outputs go to reset values asynchronously, and the first post-release hs occurs exactly 659 clocks after release.
